// File: rtl/avl_onchip_ram_dp.sv
// avl_onchip_ram_dp: true-dual-port on-chip RAM with two Avalon-MM slave
// ports (s1, s2) on one clock. It has a configurable read latency (1 or 2),
// drops out-of-range accesses and raises a sticky error flag for them, and
// gives s1 priority on same-address write collisions.
//
// Optional feature macro: AVL_ONCHIP_RAM_RDW_BYPASS_EN
//   defined   - a read on one port that hits the same in-range address the
//               other port writes in that cycle returns the new data, merged
//               per byteenable over the old word
//   undefined - such a read returns the old data
//
// INIT_FILE names an image for the memory-mapping flow to preload. This RTL
// does not load it, so the contents are undefined at power-up.
module avl_onchip_ram_dp #(
    parameter int    DATA_W       = 32,
    parameter int    ADDR_W       = 16,
    parameter int    DEPTH        = 37500,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "UNUSED"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic                clken,

    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,

    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,

    output logic                oor_err
);

    localparam int              BE_W    = DATA_W / 8;
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Elaboration-time parameter checks.
    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("avl_onchip_ram_dp: DATA_W must be a multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("avl_onchip_ram_dp: DEPTH must be in 1 .. 2**ADDR_W");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("avl_onchip_ram_dp: READ_LATENCY must be 1 or 2");
    end
    if (INIT_FILE == "") begin : g_bad_init
        $error("avl_onchip_ram_dp: INIT_FILE must be a file name or UNUSED");
    end

    // Both ports are packed side by side so that one loop handles both.
    // Index 0 is s1 and index 1 is s2.
    logic                    ce;
    logic [1:0]              cs, rd, wr;
    logic [1:0][ADDR_W-1:0]  addr;
    logic [1:0][BE_W-1:0]    be;
    logic [1:0][DATA_W-1:0]  wdata;

    logic [1:0]              wr_acc, rd_acc, in_range;
    logic [1:0][IDX_W-1:0]   idx;
    logic [1:0][DATA_W-1:0]  rd_word;

    logic [DATA_W-1:0]       mem [DEPTH];

    logic [1:0][DATA_W-1:0]  st1_data;
    logic [1:0]              st1_vld;
    logic [1:0][DATA_W-1:0]  out_data;
    logic [1:0]              out_vld;

    assign ce    = clken & ~reset_req;
    assign cs    = {s2_chipselect, s1_chipselect};
    assign rd    = {s2_read, s1_read};
    assign wr    = {s2_write, s1_write};
    assign addr  = {s2_address, s1_address};
    assign be    = {s2_byteenable, s1_byteenable};
    assign wdata = {s2_writedata, s1_writedata};

    // Accept decode and address range check for each port. When a port
    // presents read and write together, the write wins.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred
        wr_acc   = '0;
        rd_acc   = '0;
        in_range = '0;
        idx      = '0;
        for (int p = 0; p < 2; p++) begin
            in_range[p] = ({1'b0, addr[p]} < DEPTH_L);
            wr_acc[p]   = cs[p] & wr[p] & ce;
            rd_acc[p]   = cs[p] & rd[p] & ce & ~wr[p];
            idx[p]      = addr[p][IDX_W-1:0];
        end
    end

    // Byte-lane writes. s2 is applied first and s1 last, so s1 wins on the
    // lanes it enables when both ports write the same word.
    // NOTE: the RAM array has no reset; reset must leave its contents intact
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            if (wr_acc[p] && in_range[p]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be[p][b]) begin
                        mem[idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    // First-stage read word: zero when out of range, and optionally
    // forwarded from the other port's write to the same address.
    always_comb begin
        rd_word = '0;
        for (int p = 0; p < 2; p++) begin
            if (in_range[p]) begin
                rd_word[p] = mem[idx[p]];
`ifdef AVL_ONCHIP_RAM_RDW_BYPASS_EN
                if (wr_acc[1-p] && (addr[1-p] == addr[p])) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (be[1-p][b]) begin
                            rd_word[p][b*8 +: 8] = wdata[1-p][b*8 +: 8];
                        end
                    end
                end
`endif
            end
        end
    end

    // RAM output register. It loads only on an accepted read, so the data
    // holds between valid cycles, and it freezes while ce is low.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only
        if (reset) begin
            st1_data <= '0;
            st1_vld  <= '0;
        end else if (ce) begin
            for (int p = 0; p < 2; p++) begin
                st1_vld[p] <= rd_acc[p];
                if (rd_acc[p]) begin
                    st1_data[p] <= rd_word[p];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [1:0][DATA_W-1:0] st2_data;
        logic [1:0]             st2_vld;

        // Extra output register. It advances only on ce and captures data
        // only when stage one holds a valid result.
        always_ff @(posedge clk) begin
            if (reset) begin
                st2_data <= '0;
                st2_vld  <= '0;
            end else if (ce) begin
                st2_vld <= st1_vld;
                for (int p = 0; p < 2; p++) begin
                    if (st1_vld[p]) begin
                        st2_data[p] <= st1_data[p];
                    end
                end
            end
        end

        assign out_data = st2_data;
        assign out_vld  = st2_vld;
    end else begin : g_lat1
        assign out_data = st1_data;
        assign out_vld  = st1_vld;
    end

    // A valid result shows only on a ce cycle outside reset. It is
    // therefore emitted once after a stall, and never for a read that was
    // in flight when reset arrived.
    assign s1_readdata      = out_data[0];
    assign s2_readdata      = out_data[1];
    assign s1_readdatavalid = out_vld[0] & ce & ~reset;
    assign s2_readdatavalid = out_vld[1] & ce & ~reset;

    // Sticky out-of-range flag. It sets after any accepted access at or
    // above DEPTH and clears only on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            oor_err <= 1'b0;
        end else if (|((wr_acc | rd_acc) & ~in_range)) begin
            oor_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avl_onchip_ram_dp.sv
// Self-checking bench for avl_onchip_ram_dp. Two instances share all inputs:
// dut_a uses READ_LATENCY=1 and dut_b uses READ_LATENCY=2. Stimulus pushes the
// expected read data and due cycle into a per-instance, per-port queue. A
// negedge monitor pops an entry whenever readdatavalid is high and compares.
module tb_avl_onchip_ram_dp;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, reset_req, clken;
    logic [15:0] s1_address, s2_address;
    logic        s1_chipselect, s1_read, s1_write;
    logic        s2_chipselect, s2_read, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;

    logic [31:0] a_s1_rdata, a_s2_rdata, b_s1_rdata, b_s2_rdata;
    logic        a_s1_vld, a_s2_vld, b_s1_vld, b_s2_vld;
    logic        a_oor, b_oor;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb [4][$];   // 0: a.s1, 1: a.s2, 2: b.s1, 3: b.s2

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avl_onchip_ram_dp #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(a_s1_rdata), .s1_readdatavalid(a_s1_vld),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(a_s2_rdata), .s2_readdatavalid(a_s2_vld),
        .oor_err(a_oor)
    );

    avl_onchip_ram_dp #(.READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(b_s1_rdata), .s1_readdatavalid(b_s1_vld),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(b_s2_rdata), .s2_readdatavalid(b_s2_vld),
        .oor_err(b_oor)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [3:0]  vld;
        logic [31:0] dat [4];
        exp_t        e;
        vld    = {b_s2_vld, b_s1_vld, a_s2_vld, a_s1_vld};
        dat[0] = a_s1_rdata;
        dat[1] = a_s2_rdata;
        dat[2] = b_s1_rdata;
        dat[3] = b_s2_rdata;
        for (int i = 0; i < 4; i++) begin
            if (vld[i]) begin
                if (sb[i].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid[%0d]: readdatavalid=1, required 0 (cycle %0d)", i, cyc);
                end else begin
                    e = sb[i].pop_front();
                    check($sformatf("rdata[%0d]", i), dat[i], e.data);
                    check($sformatf("latency[%0d]", i), 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic clear_strobes();
        s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0; s1_byteenable = 4'h0;
        s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0; s2_byteenable = 4'h0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            clear_strobes();
        end
    endtask

    task automatic drive(input int p, input logic w, input logic r, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        if (p == 0) begin
            s1_chipselect = 1'b1; s1_write = w; s1_read = r;
            s1_address = a; s1_writedata = d; s1_byteenable = b;
        end else begin
            s2_chipselect = 1'b1; s2_write = w; s2_read = r;
            s2_address = a; s2_writedata = d; s2_byteenable = b;
        end
    endtask

    task automatic do_wr(input int p, input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
        drive(p, 1'b1, 1'b0, a, d, b);
    endtask

    // Read with expectation. extra counts the stall cycles expected before the result.
    task automatic do_rd(input int p, input logic [15:0] a, input logic [31:0] exp, input int extra);
        exp_t e;
        drive(p, 1'b0, 1'b1, a, 32'h0, 4'h0);
        e.data = exp;
        e.due  = cyc + 1 + extra;
        sb[p].push_back(e);
        e.due  = cyc + 2 + extra;
        sb[2 + p].push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " a_s1_rdata"}, a_s1_rdata, 32'h0);
        check({tag, " a_s2_rdata"}, a_s2_rdata, 32'h0);
        check({tag, " b_s1_rdata"}, b_s1_rdata, 32'h0);
        check({tag, " b_s2_rdata"}, b_s2_rdata, 32'h0);
        check({tag, " valids"}, {28'h0, a_s1_vld, a_s2_vld, b_s1_vld, b_s2_vld}, 32'h0);
        check({tag, " a_oor"}, {31'h0, a_oor}, 32'h0);
        check({tag, " b_oor"}, {31'h0, b_oor}, 32'h0);
    endtask

    initial begin
        logic [31:0] rdw_exp;
        reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
        s1_address = '0; s2_address = '0; s1_writedata = '0; s2_writedata = '0;
        clear_strobes();
        step(2);
        reset = 1'b0;
        check_reset_state("reset");

        // Full-word write on s1, read back on s2.
        do_wr(0, 16'h0010, 32'hDEADBEEF, 4'hF); step(1);
        do_rd(1, 16'h0010, 32'hDEADBEEF, 0);    step(3);

        // Partial byte-enable overwrite.
        do_wr(0, 16'd5, 32'h11223344, 4'hF); step(1);
        do_wr(0, 16'd5, 32'hAABBCCDD, 4'h6); step(1);
        do_rd(0, 16'd5, 32'h11BBCC44, 0);    step(3);

        // Preload 0..3, then stream four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            do_wr(1, 16'(i), 32'(i), 4'hF); step(1);
        end
        for (int i = 0; i < 4; i++) begin
            do_rd(0, 16'(i), 32'(i), 0); step(1);
        end
        step(3);

        // Both ports write address 7 in the same cycle.
        do_wr(0, 16'd7, 32'hFFFFFFFF, 4'h3);
        do_wr(1, 16'd7, 32'h12345678, 4'hC);
        step(1);
        do_rd(1, 16'd7, 32'h1234FFFF, 0); step(3);

        // Mixed-port read while the other port writes the same address.
`ifdef AVL_ONCHIP_RAM_RDW_BYPASS_EN
        rdw_exp = 32'hCAFEF00D;
`else
        rdw_exp = 32'h1234FFFF;
`endif
        do_wr(0, 16'd7, 32'hCAFEF00D, 4'hF);
        do_rd(1, 16'd7, rdw_exp, 0);
        step(1);
        do_rd(1, 16'd7, 32'hCAFEF00D, 0); step(3);

        // Read and write together on one port: the write wins and no valid is produced.
        drive(0, 1'b1, 1'b1, 16'd8, 32'h00000055, 4'hF); step(1);
        do_wr(0, 16'd8, 32'hFFFFFFFF, 4'h0);             step(1);
        do_rd(0, 16'd8, 32'h00000055, 0);                step(3);

        // Out-of-range accesses.
        do_wr(1, 16'd37499, 32'h0BADCAFE, 4'hF); step(1);
        check("oor before", {30'h0, a_oor, b_oor}, 32'h0);
        do_wr(1, 16'd37500, 32'h00000005, 4'hF); step(1);
        check("oor after write", {30'h0, a_oor, b_oor}, 32'h3);
        do_rd(1, 16'd37500, 32'h00000000, 0); step(1);
        do_rd(1, 16'd37499, 32'h0BADCAFE, 0); step(3);
        check("oor sticky", {30'h0, a_oor, b_oor}, 32'h3);
        reset = 1'b1; step(1); reset = 1'b0;
        check_reset_state("oor reset");

        // Stall via reset_req for three cycles while a read is in flight.
        do_rd(0, 16'h0010, 32'hDEADBEEF, 3); step(1);
        reset_req = 1'b1; step(3);
        reset_req = 1'b0; step(4);

        // Reset asserted while a read is in flight: no valid pulse ever.
        drive(0, 1'b0, 1'b1, 16'd5, 32'h0, 4'h0); step(1);
        reset = 1'b1; step(1);
        reset = 1'b0; step(4);
        check("mid-read reset a_s1_rdata", a_s1_rdata, 32'h0);
        check("mid-read reset b_s1_rdata", b_s1_rdata, 32'h0);

        // Every expected result must have been delivered.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("outstanding[%0d]", i), 32'(sb[i].size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/avl_onchip_ram_dp.md
Name: avl_onchip_ram_dp

Overview:
- Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports, s1 and s2, both on a single clock.
- Successor to the single-port on-chip memory slave. Adds:
  - configurable width, depth and read latency;
  - explicit read strobe with readdatavalid pipelining;
  - out-of-range address protection for non-power-of-two depths;
  - a defined same-address collision policy.
- Sits behind the system interconnect as program/data RAM. Typical use: s1 on the CPU, s2 on a DMA or SD-card data mover.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width.
- DEPTH, 37500, number of words; 1 <= DEPTH <= 2**ADDR_W.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
- INIT_FILE, "UNUSED", memory initialisation file; "UNUSED" means contents are undefined at power-up.

Ports:
- clk  in  1  single clock for both ports
- reset  in  1  synchronous, active-high reset
- reset_req  in  1  when high, forces clock-enable low (holds RAM and pipeline)
- clken  in  1  global clock enable
- s1_address  in  ADDR_W  s1 word address
- s1_chipselect  in  1  s1 select
- s1_read  in  1  s1 read strobe
- s1_write  in  1  s1 write strobe
- s1_byteenable  in  DATA_W/8  s1 byte lanes
- s1_writedata  in  DATA_W  s1 write data
- s1_readdata  out  DATA_W  s1 read data
- s1_readdatavalid  out  1  s1 read data qualifier
- s2_address, s2_chipselect, s2_read, s2_write, s2_byteenable, s2_writedata, s2_readdata, s2_readdatavalid: identical to the s1 ports, for port s2
- oor_err  out  1  sticky out-of-range access flag

Behaviour:
- Clock enable: ce = clken & ~reset_req. No RAM write and no pipeline advance occur when ce=0.
- Reset:
  - Synchronous, and overrides ce.
  - Clears s1/s2_readdata to 0, s1/s2_readdatavalid to 0, oor_err to 0, and flushes all read-pipeline valid bits.
  - RAM contents are not altered.
  - A read in flight when reset asserts never returns readdatavalid.
- Accept conditions, per port p:
  - Write accepted: p_chipselect & p_write & ce.
  - Read accepted: p_chipselect & p_read & ce & ~p_write.
  - If read and write are both asserted, the write wins and no readdatavalid is produced.
  - No waitrequest: every request is accepted in the cycle it is presented.
- Writes: byte lane i of the addressed word is updated iff p_byteenable[i]. byteenable = 0 performs no write.
- Reads:
  - p_readdatavalid pulses exactly READ_LATENCY ce-cycles after acceptance, with p_readdata valid in the same cycle.
  - READ_LATENCY=1: RAM output register only.
  - READ_LATENCY=2: one additional output register.
  - Back-to-back reads stream one result per cycle.
  - Outside valid cycles, p_readdata holds its last value.
- Stall: while ce=0 the pipeline freezes and p_readdatavalid is forced to 0. A frozen valid result is emitted exactly once, on the first ce=1 cycle.
- Out of range (address >= DEPTH):
  - Writes are dropped.
  - Reads return all-zero data with readdatavalid still asserted.
  - oor_err sets on the cycle after any such accepted access and stays set until reset.
  - When DEPTH = 2**ADDR_W, oor_err never sets.
- Collisions:
  - Both ports write the same address in one cycle: s1 data is stored for byte lanes s1 enables; lanes only s2 enables take s2 data.
  - Same-port read-during-write: not possible (write wins, see above).
  - Mixed-port read while the other port writes the same address: returns old data (default, see Optional Feature).

Optional Feature:
- Macro: AVL_ONCHIP_RAM_RDW_BYPASS_EN.
- Defined: a mixed-port read colliding with a write to the same in-range address in the same cycle returns the new data, merged per byteenable over the old word. This uses a forwarding mux on the first read stage and adds no latency.
- Undefined: old data is returned and no forwarding logic is built.

Test Plan:
- Default parameters. s1 writes 0xDEADBEEF to address 0x0010 (byteenable 0xF), then s2 reads 0x0010 -> s2_readdatavalid exactly 1 cycle later, s2_readdata=0xDEADBEEF.
- s1 writes 0x11223344 to address 5, then s1 writes 0xAABBCCDD to address 5 with byteenable 0x6. A read of address 5 -> 0x11BBCC44.
- READ_LATENCY=2, s1 issues 4 back-to-back reads of addresses 0..3 preloaded with 0..3 -> readdatavalid high for 4 consecutive cycles starting 2 cycles after the first read, data 0,1,2,3.
- Out of range: s2 writes 0x5 to address 37500, then reads 37500 -> readdata=0, readdatavalid=1, oor_err=1 from the cycle after the write. Address 37499 is unchanged. Assert reset -> oor_err=0.
- Same cycle, address 7: s1 writes 0xFFFFFFFF (byteenable 0x3) and s2 writes 0x12345678 (byteenable 0xC) -> a read of address 7 returns 0x1234FFFF.
- Issue a read, then hold reset_req high for 3 cycles before readdatavalid -> no valid pulse during the stall, exactly one valid pulse after release. Reset asserted mid-read -> no valid pulse at all.
